// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset controller.
// Holds all downstream stages in reset until the PLL lock has been stable
// and a minimum hold time has elapsed. It then releases STAGES active-low
// resets in order, bit 0 first, spaced STAGE_DELAY cycles apart. It
// returns to HOLD on lock loss, or on a software request made while in RUN.
//
// Ports:
//   clk             - single clock, rising edge
//   n_reset         - asynchronous active-low reset
//   pll_lock        - PLL lock indicator (synchronous to clk)
//   soft_req        - software reset request, honoured only in RUN
//   n_stage_reset   - active-low stage resets, bit 0 released first
//   ready           - high while every stage is released (RUN)
//   soft_ack        - one-cycle pulse when a soft-reset sequence completes
//   lock_lost_count - saturating count of lock-loss events
module reset_sequencer #(
    parameter int unsigned STAGES      = 3,
    parameter int unsigned STAGE_DELAY = 16,
    parameter int unsigned LOCK_FILTER = 4,
    parameter int unsigned MIN_ASSERT  = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              pll_lock,
    input  logic              soft_req,
    output logic [STAGES-1:0] n_stage_reset,
    output logic              ready,
    output logic              soft_ack,
    output logic [3:0]        lock_lost_count
);
    localparam int unsigned LOCK_W = $clog2(LOCK_FILTER) + 1;
    localparam int unsigned HOLD_W = $clog2(MIN_ASSERT) + 1;
    localparam int unsigned DLY_W  = $clog2(STAGE_DELAY) + 1;
    localparam int unsigned IDX_W  = $clog2(STAGES) + 1;

    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_FILTER);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_ASSERT);
    localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(STAGES - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t             state;
    logic [LOCK_W-1:0]  lock_ctr;
    logic [HOLD_W-1:0]  hold_ctr;
    logic [DLY_W-1:0]   dly_ctr;
    logic [IDX_W-1:0]   stage_idx;
    logic               soft_pending;

    logic [LOCK_W:0]    lock_next_c;
    logic [HOLD_W:0]    hold_next_c;
    logic               lock_ok_c;
    logic               hold_ok_c;
    logic               lock_lost_c;
    logic [STAGES-1:0]  stage_bit_c;

    // Thresholds are compared as "count + 1 >= bound" on a widened value, so
    // a bound of 1 does not turn into an always-true unsigned compare.
    assign lock_next_c = {1'b0, lock_ctr} + (LOCK_W + 1)'(1);
    assign hold_next_c = {1'b0, hold_ctr} + (HOLD_W + 1)'(1);
    assign lock_ok_c   = pll_lock && (lock_next_c >= (LOCK_W + 1)'(LOCK_FILTER));
    assign hold_ok_c   = hold_next_c >= (HOLD_W + 1)'(MIN_ASSERT);

    // Lock loss is only an event once something has been released.
    assign lock_lost_c = (state != S_HOLD) && !pll_lock;

    // One-hot mask of the stage that releases next.
    always_comb begin
        stage_bit_c = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            stage_bit_c[i] = (IDX_W'(i) == stage_idx);
        end
    end

    // Lock filter, sequencing FSM and registered outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state           <= S_HOLD;
            lock_ctr        <= '0;
            hold_ctr        <= '0;
            dly_ctr         <= '0;
            stage_idx       <= '0;
            soft_pending    <= 1'b0;
            n_stage_reset   <= '0;
            ready           <= 1'b0;
            soft_ack        <= 1'b0;
            lock_lost_count <= '0;
        end else begin
            soft_ack <= 1'b0;

            if (!pll_lock) begin
                lock_ctr <= '0;
            end else if (lock_ctr != LOCK_MAX) begin
                lock_ctr <= lock_ctr + LOCK_W'(1);
            end

            if (lock_lost_c) begin
                // Lock loss wins over a simultaneous soft request.
                state         <= S_HOLD;
                n_stage_reset <= '0;
                ready         <= 1'b0;
                hold_ctr      <= '0;
                dly_ctr       <= '0;
                stage_idx     <= '0;
                soft_pending  <= 1'b0;
                if (lock_lost_count != 4'hF) begin
                    lock_lost_count <= lock_lost_count + 4'd1;
                end
            end else begin
                unique case (state)
                    S_HOLD: begin
                        if (hold_ctr != HOLD_MAX) begin
                            hold_ctr <= hold_ctr + HOLD_W'(1);
                        end
                        if (lock_ok_c && hold_ok_c) begin
                            n_stage_reset <= STAGES'(1);
                            dly_ctr       <= '0;
                            stage_idx     <= IDX_W'(1);
                            if (STAGES == 1) begin
                                state        <= S_RUN;
                                ready        <= 1'b1;
                                soft_ack     <= soft_pending;
                                soft_pending <= 1'b0;
                            end else begin
                                state <= S_RELEASE;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (dly_ctr == DLY_LAST) begin
                            n_stage_reset <= n_stage_reset | stage_bit_c;
                            dly_ctr       <= '0;
                            stage_idx     <= stage_idx + IDX_W'(1);
                            if (stage_idx == IDX_LAST) begin
                                state        <= S_RUN;
                                ready        <= 1'b1;
                                soft_ack     <= soft_pending;
                                soft_pending <= 1'b0;
                            end
                        end else begin
                            dly_ctr <= dly_ctr + DLY_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (soft_req) begin
                            // Lock filter history is kept across a soft reset.
                            state         <= S_HOLD;
                            n_stage_reset <= '0;
                            ready         <= 1'b0;
                            hold_ctr      <= '0;
                            dly_ctr       <= '0;
                            stage_idx     <= '0;
                            soft_pending  <= 1'b1;
                        end
                    end
                    default: begin
                        state         <= S_HOLD;
                        n_stage_reset <= '0;
                        ready         <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
